// File: rtl/uart_pkg.sv
// Shared UART controller types: byte width and the common FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_GAP  = 2'b10
    } uart_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin selector: first asserted req at or above ptr, wrapping at NREQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [PW-1:0]   index,
    output logic            any
);

    // Rank every requester by its wrapped distance from ptr; the closest active one wins.
    always_comb begin : pick
        int best_d;
        int d;
        best_d = NREQ;
        d      = 0;
        index  = '0;
        onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            d = i - int'(ptr);
            if (d < 0) begin
                d = d + NREQ;
            end
            if (req[i] && (d < best_d)) begin
                best_d = d;
                index  = PW'(i);
            end
        end
        any = (best_d < NREQ);
        for (int i = 0; i < NREQ; i++) begin
            onehot[i] = any && (index == PW'(i));
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NREQ byte streams, round-robin per frame, with an inter-frame gap.
// Latency: grant one clock after request; bytes pass combinationally from owner to uart_tx.
// Backpressure: tx_ready feeds straight back to the owner's req_ready; owner stalls revoke after TIMEOUT.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [UART_DATA_W*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]               req_last,
    output logic [NREQ-1:0]               req_ready,
    output logic                          tx_valid,
    output logic [UART_DATA_W-1:0]        tx_data,
    input  logic                          tx_ready,
    output logic [NREQ-1:0]               gnt,
    output logic                          busy,
    output logic                          abort
);

    localparam int PW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int GW = $clog2(GAP_CYCLES) + 1;
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    // Where a frame goes when it ends, whether by last byte or by timeout.
    localparam uart_state_e END_STATE = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

    uart_state_e            state, state_nxt;
    logic [NREQ-1:0]        gnt_q, gnt_nxt;
    logic [PW-1:0]          owner, owner_nxt;
    logic [PW-1:0]          ptr, ptr_nxt, ptr_after;
    logic [TW-1:0]          to_cnt, to_cnt_nxt;
    logic [GW-1:0]          gap_cnt, gap_cnt_nxt;
    logic                   abort_nxt;

    logic [NREQ-1:0]        pick_onehot;
    logic [PW-1:0]          pick_index;
    logic                   pick_any;

    logic [UART_DATA_W-1:0] req_bytes [NREQ];
    logic                   send, own_vld, own_last, hs;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req    (req_valid),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .index  (pick_index),
        .any    (pick_any)
    );

    // Split the flat data bus into per-requester bytes so the owner mux is a plain array index.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_bytes[i] = req_data[i*UART_DATA_W +: UART_DATA_W];
        end
    end

    // Owner-to-uart_tx datapath; everything is gated by SEND so IDLE/GAP present zeros.
    always_comb begin
        send      = (state == ST_SEND);
        own_vld   = send && req_valid[owner];
        own_last  = req_last[owner];
        hs        = own_vld && tx_ready;
        tx_valid  = own_vld;
        tx_data   = send ? req_bytes[owner] : '0;
        req_ready = send ? (gnt_q & {NREQ{tx_ready}}) : '0;
        ptr_after = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
    end

    assign gnt  = gnt_q;
    assign busy = (state != ST_IDLE);

    // Next-state logic: grant in IDLE, track stall timeout in SEND, count the gap in GAP.
    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt_q;
        owner_nxt   = owner;
        ptr_nxt     = ptr;
        to_cnt_nxt  = to_cnt;
        gap_cnt_nxt = gap_cnt;
        abort_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_nxt  = ST_SEND;
                    gnt_nxt    = pick_onehot;
                    owner_nxt  = pick_index;
                    to_cnt_nxt = '0;
                end
            end
            ST_SEND: begin
                if (hs) begin
                    // A handshake always beats an expiring timeout, even on the last byte.
                    to_cnt_nxt = '0;
                    if (own_last) begin
                        state_nxt   = END_STATE;
                        gnt_nxt     = '0;
                        ptr_nxt     = ptr_after;
                        gap_cnt_nxt = '0;
                    end
                end else if (!own_vld) begin
                    if (to_cnt == TO_LAST) begin
                        state_nxt   = END_STATE;
                        gnt_nxt     = '0;
                        ptr_nxt     = ptr_after;
                        gap_cnt_nxt = '0;
                        abort_nxt   = 1'b1;
                    end else begin
                        to_cnt_nxt = to_cnt + 1'b1;
                    end
                end
                // valid high with tx_ready low is uart_tx backpressure: counter holds.
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt   = ST_IDLE;
                    gap_cnt_nxt = '0;
                end else begin
                    gap_cnt_nxt = gap_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    // State register; reset drops any frame in flight without an abort pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            gnt_q   <= '0;
            owner   <= '0;
            ptr     <= '0;
            to_cnt  <= '0;
            gap_cnt <= '0;
            abort   <= 1'b0;
        end else begin
            state   <= state_nxt;
            gnt_q   <= gnt_nxt;
            owner   <= owner_nxt;
            ptr     <= ptr_nxt;
            to_cnt  <= to_cnt_nxt;
            gap_cnt <= gap_cnt_nxt;
            abort   <= abort_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, rotation table, backpressure, stall, reset mid-frame.
// Latency: n/a.
// Backpressure: tx_ready driven by the stimulus.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [3:0]  rv0, rl0, rr0, gnt0;
    logic [31:0] rd0;
    logic        txv0, txr0, busy0, abort0;
    logic [7:0]  txd0;

    logic [3:0]  rv1, rl1, rr1, gnt1;
    logic [31:0] rd1;
    logic        txv1, txr1, busy1, abort1;
    logic [7:0]  txd1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] rv;
        logic [3:0] exp_gnt;
    } rr_vec_t;

    rr_vec_t tbl [10];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(4), .GAP_CYCLES(16), .TIMEOUT(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv0), .req_data(rd0), .req_last(rl0),
        .req_ready(rr0), .tx_valid(txv0), .tx_data(txd0), .tx_ready(txr0),
        .gnt(gnt0), .busy(busy0), .abort(abort0)
    );

    uart_tx_arbiter #(.NREQ(4), .GAP_CYCLES(2), .TIMEOUT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_data(rd1), .req_last(rl1),
        .req_ready(rr1), .tx_valid(txv1), .tx_data(txd1), .tx_ready(txr1),
        .gnt(gnt1), .busy(busy1), .abort(abort1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int oh2idx(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) return i;
        end
        return 0;
    endfunction

    task automatic wait_idle(input bit d1, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk); #1;
            if ((d1 ? busy1 : busy0) == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_gnt0(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk); #1;
            if (gnt0 != 4'b0000) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit         ok;
        int         k, abort_cnt, abort_at;
        logic [7:0] bp_bytes [4];

        tbl[0] = '{4'b1111, 4'b0001};
        tbl[1] = '{4'b1111, 4'b0010};
        tbl[2] = '{4'b1111, 4'b0100};
        tbl[3] = '{4'b1111, 4'b1000};
        tbl[4] = '{4'b1111, 4'b0001};
        tbl[5] = '{4'b0001, 4'b0001};
        tbl[6] = '{4'b1001, 4'b1000};
        tbl[7] = '{4'b0110, 4'b0010};
        tbl[8] = '{4'b0110, 4'b0100};
        tbl[9] = '{4'b0010, 4'b0010};
        bp_bytes[0] = 8'h11; bp_bytes[1] = 8'h22; bp_bytes[2] = 8'h33; bp_bytes[3] = 8'h44;

        rst_n = 1'b0;
        rv0 = '0; rl0 = '0; rd0 = '0; txr0 = 1'b0;
        rv1 = '0; rl1 = '0; rd1 = '0; txr1 = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_gnt", gnt0, 4'b0000);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_abort", abort0, 1'b0);
        chk("rst_txv", txv0, 1'b0);
        chk("rst_ready", rr0, 4'b0000);
        chk("rst_txd", txd0, 8'h00);

        // Single 3-byte frame from requester 2, then the 16-clock gap.
        rst_n = 1'b1;
        rv0[2] = 1'b1; rd0[23:16] = 8'hA5; rl0[2] = 1'b0; txr0 = 1'b1;
        #1;
        chk("t1_no_gnt_yet", gnt0, 4'b0000);
        @(negedge clk); #1;
        chk("t1_gnt", gnt0, 4'b0100);
        chk("t1_txv", txv0, 1'b1);
        chk("t1_byte0", txd0, 8'hA5);
        chk("t1_ready", rr0, 4'b0100);
        @(negedge clk); rd0[23:16] = 8'h5A; #1;
        chk("t1_byte1", txd0, 8'h5A);
        @(negedge clk); rd0[23:16] = 8'hFF; rl0[2] = 1'b1; #1;
        chk("t1_byte2", txd0, 8'hFF);
        @(negedge clk); rv0[2] = 1'b0; rl0[2] = 1'b0; #1;
        chk("t1_gnt_clr", gnt0, 4'b0000);
        chk("t1_gap_busy", busy0, 1'b1);
        repeat (15) @(negedge clk);
        #1;
        chk("t1_busy_15", busy0, 1'b1);
        @(negedge clk); #1;
        chk("t1_busy_16", busy0, 1'b0);

        // Fresh pointer, then the rotation table of single-byte frames.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        rl0 = 4'hF; txr0 = 1'b1;
        for (int i = 0; i < 4; i++) rd0[8*i +: 8] = 8'(8'h10 + i);
        for (int v = 0; v < 10; v++) begin
            rv0 = tbl[v].rv;
            wait_gnt0(ok);
            chk("rr_gnt_seen", ok, 1'b1);
            chk("rr_gnt", gnt0, tbl[v].exp_gnt);
            chk("rr_data", txd0, 32'(8'h10 + oh2idx(tbl[v].exp_gnt)));
            chk("rr_ready", rr0, tbl[v].exp_gnt);
            wait_idle(1'b0, ok);
            chk("rr_idle", ok, 1'b1);
        end
        rv0 = '0; rl0 = '0;

        // Backpressure: tx_ready high one clock in ten; valid stays high so no abort.
        rv0 = 4'b1000; rd0[31:24] = bp_bytes[0];
        k = 0; abort_cnt = 0;
        for (int c = 0; c < 120 && k < 4; c++) begin
            @(negedge clk);
            rd0[31:24] = bp_bytes[k];
            rl0[3] = (k == 3);
            txr0 = ((c % 10) == 9);
            #1;
            if (abort0) abort_cnt++;
            if (txv0 && txr0) begin
                chk("bp_gnt", gnt0, 4'b1000);
                chk("bp_byte", txd0, bp_bytes[k]);
                k++;
            end
        end
        chk("bp_count", k, 4);
        chk("bp_abort", abort_cnt, 0);
        @(negedge clk); rv0 = '0; rl0 = '0; txr0 = 1'b1;
        wait_idle(1'b0, ok);
        chk("bp_idle", ok, 1'b1);

        // Stall: owner 1 sends one byte then goes quiet; requester 2 waits its turn.
        rv0 = 4'b0110; rd0[15:8] = 8'h77; rl0[1] = 1'b0; rd0[23:16] = 8'h88; rl0[2] = 1'b1;
        @(negedge clk); #1;
        chk("st_gnt", gnt0, 4'b0010);
        chk("st_byte", txd0, 8'h77);
        @(negedge clk); rv0[1] = 1'b0;
        abort_cnt = 0; abort_at = -1;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk); #1;
            if (abort0) begin
                abort_cnt++;
                if (abort_at < 0) abort_at = j;
            end
            if (j == 8) chk("st_gnt_clr", gnt0, 4'b0000);
        end
        chk("st_abort_cnt", abort_cnt, 1);
        chk("st_abort_at", abort_at, 8);
        wait_gnt0(ok);
        chk("st_next_seen", ok, 1'b1);
        chk("st_next_gnt", gnt0, 4'b0100);
        chk("st_next_data", txd0, 8'h88);
        chk("st_next_ready", rr0, 4'b0100);
        @(negedge clk); rv0 = '0; rl0 = '0;
        wait_idle(1'b0, ok);
        chk("st_idle", ok, 1'b1);

        // Reset after byte 2 of a 5-byte frame from requester 0.
        rv0 = 4'b0001; rd0[7:0] = 8'hB1; rl0[0] = 1'b0;
        @(negedge clk); #1;
        chk("rm_gnt", gnt0, 4'b0001);
        chk("rm_byte1", txd0, 8'hB1);
        @(negedge clk); rd0[7:0] = 8'hB2; #1;
        chk("rm_byte2", txd0, 8'hB2);
        @(negedge clk); rd0[7:0] = 8'hB3; rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        rv0 = 4'b1010; rd0[15:8] = 8'h61; rd0[31:24] = 8'h63; rl0 = 4'b1010;
        #1;
        chk("rm_gnt_rst", gnt0, 4'b0000);
        chk("rm_busy_rst", busy0, 1'b0);
        chk("rm_txv_rst", txv0, 1'b0);
        chk("rm_ready_rst", rr0, 4'b0000);
        chk("rm_txd_rst", txd0, 8'h00);
        chk("rm_abort_rst", abort0, 1'b0);
        @(negedge clk); #1;
        chk("rm_ptr_gnt", gnt0, 4'b0010);
        chk("rm_ptr_data", txd0, 8'h61);
        chk("rm_abort_after", abort0, 1'b0);
        @(negedge clk); rv0 = '0; rl0 = '0;
        wait_idle(1'b0, ok);
        chk("rm_idle", ok, 1'b1);

        // TIMEOUT=1: last-byte handshake on the would-expire cycle, then a real one-cycle stall.
        rv1 = 4'b0001; rd1[7:0] = 8'hC3; rl1 = 4'b0001; txr1 = 1'b1;
        @(negedge clk); #1;
        chk("e_gnt", gnt1, 4'b0001);
        chk("e_txv", txv1, 1'b1);
        chk("e_byte", txd1, 8'hC3);
        @(negedge clk); rv1 = '0; rl1 = '0; #1;
        chk("e_abort", abort1, 1'b0);
        chk("e_gap", busy1, 1'b1);
        chk("e_gnt_clr", gnt1, 4'b0000);
        wait_idle(1'b1, ok);
        chk("e_idle", ok, 1'b1);
        rv1 = 4'b0010; rd1[15:8] = 8'hD4; rl1 = 4'b0000;
        @(negedge clk); rv1 = '0; #1;
        chk("e2_gnt", gnt1, 4'b0010);
        chk("e2_txv", txv1, 1'b0);
        @(negedge clk); #1;
        chk("e2_abort", abort1, 1'b1);
        chk("e2_gnt_clr", gnt1, 4'b0000);
        @(negedge clk); #1;
        chk("e2_abort_pulse", abort1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NREQ byte-stream requesters, with round-robin arbitration at frame granularity.
- A granted requester keeps the transmitter until its last byte is accepted or it stalls past a timeout.
- An inter-frame gap is inserted between frames.
- Sits between the host-side message sources and the single uart_tx instance, alongside uart_rx on the same clock.

Parameters:
- NREQ, 4, number of requesters (2..8).
- GAP_CYCLES, 16, idle clocks inserted after each frame; 0 means no gap.
- TIMEOUT, 1024, clocks a granted requester may hold req_valid low mid-frame before the grant is revoked.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NREQ  per-requester byte valid.
- req_data  in  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NREQ  marks the final byte of the frame.
- req_ready  out  NREQ  byte accepted when req_valid[i] && req_ready[i].
- tx_valid  out  1  byte offered to uart_tx.
- tx_data  out  8  byte to uart_tx.
- tx_ready  in  1  uart_tx can accept a byte (idle).
- gnt  out  NREQ  one-hot current owner; all zero when idle.
- busy  out  1  high in SEND or GAP.
- abort  out  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE; gnt=0; busy=0; abort=0; tx_valid=0; req_ready=0; tx_data=0.
  - Priority pointer = 0, so requester 0 has highest priority after reset.
  - Timeout and gap counters = 0.
  - Reset mid-frame drops the frame immediately, with no abort pulse.
- States: IDLE, SEND, GAP.
- IDLE:
  - If any req_valid is high, pick the first index at or above the pointer whose req_valid is high, wrapping modulo NREQ.
  - Register gnt=onehot(sel) and go to SEND. The grant is visible the cycle after the request.
  - No byte is accepted in IDLE.
- SEND:
  - Owner g: tx_valid=req_valid[g]; tx_data=req_data[g]; req_ready[g]=tx_ready; other req_ready bits stay 0. These are combinational from gnt.
  - A handshake is req_valid[g] && tx_ready in the same cycle.
  - Handshake with req_last[g]=1: go to GAP (or to IDLE if GAP_CYCLES=0); pointer=(g+1) mod NREQ; gnt clears the next cycle.
  - Timeout counter: cleared on every handshake and on entry to SEND; increments while req_valid[g]=0.
  - tx_ready low while req_valid[g]=1 is backpressure, not a stall: the counter holds.
  - Counter reaches TIMEOUT-1 with req_valid still low: pulse abort for 1 cycle, pointer=(g+1) mod NREQ, go to GAP.
  - Bytes already sent are not retracted.
- GAP:
  - tx_valid=0; all req_ready=0; gnt=0; busy=1.
  - Count GAP_CYCLES clocks, then go to IDLE. IDLE may grant on its first cycle.
- Simultaneous events:
  - Requests arriving during SEND or GAP wait; they are not lost.
  - A single-byte frame (req_last on the first byte) is legal.
  - If req_last and the timeout expiry land on the same cycle, the handshake wins; no abort.
- Fairness: with all NREQ requesting continuously, grants rotate 0,1,..,NREQ-1,0.
- Width rules:
  - Pointer is clog2(NREQ) bits, with explicit wrap at NREQ (non-power-of-two NREQ supported).
  - Counters are sized clog2 of their parameter +1 bits and saturate-safe.
- Requester obligation: req_data/req_last must be stable while req_valid is high and not yet accepted. The arbiter does not check this.

Decomposition:
- Shared package uart_pkg:
  - State encoding constants ST_IDLE=2'b00, ST_SEND=2'b01, ST_GAP=2'b10, shared with the other UART controllers.
  - UART_DATA_W=8.
- One natural sub-module: rr_pick. Combinational round-robin selector with inputs req[NREQ] and ptr, outputs onehot[NREQ], index, any. It is reused by future arbiters.
- Counters and the FSM stay in uart_tx_arbiter.

Test Plan:
- Reset then single request (NREQ=4, GAP_CYCLES=16): req 2 sends 3 bytes 0xA5,0x5A,0xFF with last on 0xFF, tx_ready=1 → gnt=4'b0100 one cycle after valid; tx_data sequence A5,5A,FF; busy low exactly 16 clocks after the last handshake.
- All four requesting continuous 1-byte frames → grant order 0,1,2,3,0; tx_data matches each owner; no req_ready to a non-owner.
- Backpressure: tx_ready toggles 1 of every 10 clocks during a 4-byte frame (TIMEOUT=8) → all 4 bytes delivered in order; abort never asserts.
- Stall: owner 1 sends 1 byte then drops req_valid for 20 clocks (TIMEOUT=8) → abort pulses exactly once, 8 clocks after the drop; gnt clears; next grant goes to 2 if pending.
- Reset mid-frame: rst_n low for 1 clock after byte 2 of 5 → all outputs at reset values the next cycle; pointer=0; no abort.
- Simultaneous last and timeout edge (TIMEOUT=1), with a req_last handshake on the would-expire cycle → GAP entered; abort stays 0.
